// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, IDLE/RUN control.
// Latency: IF/ID captures {pc_o, imem_data_i} one clock after the fetch address is presented.
// Backpressure: stall_i holds PC and IF/ID; branch_i/flush_i override stall_i; start_i low idles the stage.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), asynchronous active-low reset
//   start_i                 run enable; low idles the stage (PC frozen, IF/ID bubbles)
//   stall_i, flush_i        hazard-unit hold / squash requests
//   branch_i,
//   branch_target_i         taken redirect from ID, word-aligned on load
//   imem_addr_o,
//   imem_data_i             instruction memory request (address == pc_o), combinational read data
//   pc_o                    current fetch PC
//   ifid_pc_o, ifid_instr_o,
//   ifid_valid_o            IF/ID register contents
//   stall_cnt_o,
//   flush_cnt_o             event counters, present only when IF_STAGE_PERF_CNT_EN is defined
//                           (otherwise tied to zero)

module if_stage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   output logic [31:0] pc_o,
   output logic [31:0] ifid_pc_o,
   output logic [31:0] ifid_instr_o,
   output logic        ifid_valid_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      PC_HOLD = 2'd0,
      PC_INC  = 2'd1,
      PC_JUMP = 2'd2
   } pc_op_t;

   typedef enum logic [1:0] {
      IFID_BUBBLE = 2'd0,
      IFID_LOAD   = 2'd1,
      IFID_HOLD   = 2'd2
   } ifid_op_t;

   state_t   state;
   state_t   state_nxt;
   pc_op_t   pc_op;
   ifid_op_t ifid_op;

   logic [31:0] pc;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;

`ifdef IF_STAGE_PERF_CNT_EN
   logic        stall_evt;
   logic        flush_evt;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i)  state_nxt = RUN;
         RUN:     if (!start_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Output / datapath control decode
   // A RUN cycle whose start_i has already dropped behaves like IDLE:
   // any redirect or stall presented on that edge is discarded so the
   // PC keeps its pre-redirect value.
   // ---------------------------------------------------------------
   always_comb begin
      pc_op   = PC_HOLD;
      ifid_op = IFID_BUBBLE;
`ifdef IF_STAGE_PERF_CNT_EN
      stall_evt = 1'b0;
      flush_evt = 1'b0;
`endif
      case (state)
         RUN: begin
            if (start_i) begin
               if (branch_i) begin
                  pc_op   = PC_JUMP;
                  ifid_op = IFID_BUBBLE;
`ifdef IF_STAGE_PERF_CNT_EN
                  flush_evt = 1'b1;
`endif
               end else if (flush_i) begin
                  pc_op   = PC_INC;
                  ifid_op = IFID_BUBBLE;
`ifdef IF_STAGE_PERF_CNT_EN
                  flush_evt = 1'b1;
`endif
               end else if (stall_i) begin
                  pc_op   = PC_HOLD;
                  ifid_op = IFID_HOLD;
`ifdef IF_STAGE_PERF_CNT_EN
                  stall_evt = 1'b1;
`endif
               end else begin
                  pc_op   = PC_INC;
                  ifid_op = IFID_LOAD;
               end
            end
         end
         default: begin
            pc_op   = PC_HOLD;
            ifid_op = IFID_BUBBLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // PC register; +4 wraps 32'hFFFF_FFFC to 0 by natural overflow.
   // Redirect targets are forced to word alignment.
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc <= 32'h0;
      end else begin
         case (pc_op)
            PC_INC:  pc <= pc + 32'd4;
            PC_JUMP: pc <= branch_target_i & 32'hFFFF_FFFC;
            default: pc <= pc;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // IF/ID register; a bubble is all-zero with valid cleared.
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ifid_pc    <= 32'h0;
         ifid_instr <= 32'h0;
         ifid_valid <= 1'b0;
      end else begin
         case (ifid_op)
            IFID_LOAD: begin
               ifid_pc    <= pc;
               ifid_instr <= imem_data_i;
               ifid_valid <= 1'b1;
            end
            IFID_HOLD: begin
               ifid_pc    <= ifid_pc;
               ifid_instr <= ifid_instr;
               ifid_valid <= ifid_valid;
            end
            default: begin
               ifid_pc    <= 32'h0;
               ifid_instr <= 32'h0;
               ifid_valid <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Event counters (wrap at 2^32)
   // ---------------------------------------------------------------
`ifdef IF_STAGE_PERF_CNT_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt <= 32'h0;
         flush_cnt <= 32'h0;
      end else begin
         if (stall_evt) stall_cnt <= stall_cnt + 32'd1;
         if (flush_evt) flush_cnt <= flush_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt;
   assign flush_cnt_o = flush_cnt;
`else
   assign stall_cnt_o = 32'h0;
   assign flush_cnt_o = 32'h0;
`endif

   assign pc_o         = pc;
   assign imem_addr_o  = pc;
   assign ifid_pc_o    = ifid_pc;
   assign ifid_instr_o = ifid_instr;
   assign ifid_valid_o = ifid_valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand-written
// reset sequences, then randomized traffic against a behavioural model.

module tb_if_stage;

`ifdef IF_STAGE_PERF_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        branch_i = 1'b0;
   logic [31:0] branch_target_i = 32'h0;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_data_i;
   logic [31:0] pc_o;
   logic [31:0] ifid_pc_o;
   logic [31:0] ifid_instr_o;
   logic        ifid_valid_o;
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   // Instruction memory contents are a fixed hash of the byte address.
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign imem_data_i = imem_word(imem_addr_o);

   if_stage dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .start_i         (start_i),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .branch_i        (branch_i),
      .branch_target_i (branch_target_i),
      .imem_addr_o     (imem_addr_o),
      .imem_data_i     (imem_data_i),
      .pc_o            (pc_o),
      .ifid_pc_o       (ifid_pc_o),
      .ifid_instr_o    (ifid_instr_o),
      .ifid_valid_o    (ifid_valid_o),
      .stall_cnt_o     (stall_cnt_o),
      .flush_cnt_o     (flush_cnt_o)
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                            input logic [31:0] e_instr, input logic e_v,
                            input logic [31:0] e_sc, input logic [31:0] e_fc);
      check32({tag, " pc"},        pc_o,         e_pc);
      check32({tag, " imem_addr"}, imem_addr_o,  e_pc);
      check32({tag, " ifid_pc"},   ifid_pc_o,    e_ipc);
      check32({tag, " ifid_inst"}, ifid_instr_o, e_instr);
      check32({tag, " ifid_vld"},  {31'h0, ifid_valid_o}, {31'h0, e_v});
      check32({tag, " stall_cnt"}, stall_cnt_o,  CNT_EN ? e_sc : 32'h0);
      check32({tag, " flush_cnt"}, flush_cnt_o,  CNT_EN ? e_fc : 32'h0);
   endtask

   // ---------------------------------------------------------------
   // Directed vector table
   // ---------------------------------------------------------------
   typedef struct {
      logic        start, stall, flush, branch;
      logic [31:0] tgt;
      logic [31:0] pc, ipc;
      logic        v;
      logic [31:0] sc, fc;
   } vec_t;

   function automatic vec_t mk(input logic s, input logic st, input logic f, input logic b,
                               input logic [31:0] t, input logic [31:0] pc, input logic [31:0] ipc,
                               input logic v, input logic [31:0] sc, input logic [31:0] fc);
      vec_t r;
      r.start = s; r.stall = st; r.flush = f; r.branch = b; r.tgt = t;
      r.pc = pc; r.ipc = ipc; r.v = v; r.sc = sc; r.fc = fc;
      return r;
   endfunction

   localparam int NV = 19;
   vec_t vt [NV];

   // ---------------------------------------------------------------
   // Behavioural reference model
   // ---------------------------------------------------------------
   logic        m_run;
   logic [31:0] m_pc, m_ipc, m_instr, m_sc, m_fc;
   logic        m_v;

   task automatic model_reset();
      m_run = 1'b0; m_pc = 32'h0; m_ipc = 32'h0; m_instr = 32'h0; m_v = 1'b0;
      m_sc = 32'h0; m_fc = 32'h0;
   endtask

   task automatic model_bubble();
      m_ipc = 32'h0; m_instr = 32'h0; m_v = 1'b0;
   endtask

   // One rising edge worth of behaviour for the given inputs.
   task automatic model_step(input logic s, input logic st, input logic f, input logic b,
                             input logic [31:0] t);
      if (m_run && s) begin
         if (b) begin
            m_pc = {t[31:2], 2'b00};
            model_bubble();
            m_fc = m_fc + 1;
         end else if (f) begin
            m_pc = m_pc + 4;
            model_bubble();
            m_fc = m_fc + 1;
         end else if (st) begin
            m_sc = m_sc + 1;
         end else begin
            m_ipc = m_pc; m_instr = imem_word(m_pc); m_v = 1'b1;
            m_pc = m_pc + 4;
         end
      end else begin
         model_bubble();
      end
      m_run = s;
   endtask

   initial begin
      //              st st fl br target          pc             ifid_pc      v  sc fc
      vt[0]  = mk(1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         0, 0, 0);
      vt[1]  = mk(1, 0, 0, 0, 32'h0,          32'h4,         32'h0,         1, 0, 0);
      vt[2]  = mk(1, 0, 0, 0, 32'h0,          32'h8,         32'h4,         1, 0, 0);
      vt[3]  = mk(1, 1, 0, 0, 32'h0,          32'h8,         32'h4,         1, 1, 0);
      vt[4]  = mk(1, 1, 0, 0, 32'h0,          32'h8,         32'h4,         1, 2, 0);
      vt[5]  = mk(1, 0, 0, 0, 32'h0,          32'hC,         32'h8,         1, 2, 0);
      vt[6]  = mk(1, 1, 0, 1, 32'h43,         32'h40,        32'h0,         0, 2, 1);
      vt[7]  = mk(1, 0, 0, 1, 32'h12,         32'h10,        32'h0,         0, 2, 2);
      vt[8]  = mk(1, 0, 1, 0, 32'h0,          32'h14,        32'h0,         0, 2, 3);
      vt[9]  = mk(1, 0, 0, 0, 32'h0,          32'h18,        32'h14,        1, 2, 3);
      vt[10] = mk(1, 0, 0, 1, 32'hFFFF_FFFF,  32'hFFFF_FFFC, 32'h0,         0, 2, 4);
      vt[11] = mk(1, 0, 0, 0, 32'h0,          32'h0,         32'hFFFF_FFFC, 1, 2, 4);
      vt[12] = mk(1, 1, 1, 1, 32'h100,        32'h100,       32'h0,         0, 2, 5);
      vt[13] = mk(1, 1, 1, 0, 32'h0,          32'h104,       32'h0,         0, 2, 6);
      vt[14] = mk(1, 0, 0, 0, 32'h0,          32'h108,       32'h104,       1, 2, 6);
      vt[15] = mk(0, 1, 0, 1, 32'h200,        32'h108,       32'h0,         0, 2, 6);
      vt[16] = mk(0, 0, 0, 0, 32'h0,          32'h108,       32'h0,         0, 2, 6);
      vt[17] = mk(1, 0, 0, 0, 32'h0,          32'h108,       32'h0,         0, 2, 6);
      vt[18] = mk(1, 0, 0, 0, 32'h0,          32'h10C,       32'h108,       1, 2, 6);

      // Reset state while reset is held
      rst_i = 1'b0;
      start_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      rst_i = 1'b1;

      for (int i = 0; i < NV; i++) begin
         if (i != 0) @(negedge clk_i);
         start_i = vt[i].start; stall_i = vt[i].stall; flush_i = vt[i].flush;
         branch_i = vt[i].branch; branch_target_i = vt[i].tgt;
         @(posedge clk_i);
         #1;
         check_all($sformatf("vec%0d", i), vt[i].pc, vt[i].ipc,
                   vt[i].v ? imem_word(vt[i].ipc) : 32'h0, vt[i].v, vt[i].sc, vt[i].fc);
      end

      // Asynchronous reset mid-cycle while running: outputs clear before the next edge
      @(negedge clk_i);
      start_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; branch_i = 1'b0;
      @(posedge clk_i);
      #3;
      rst_i = 1'b0;
      #1;
      check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk_i);
      #1;
      check_all("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

      // Release with start low: PC frozen, bubbles
      @(negedge clk_i);
      rst_i = 1'b1; start_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check_all("idle_after_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

      // Randomized traffic against the model
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         logic        s, st, f, b;
         logic [31:0] t;
         @(negedge clk_i);
         if ($urandom_range(0, 199) == 0) begin
            rst_i = 1'b0;
            #1;
            model_reset();
            check_all($sformatf("rnd_rst%0d", n), m_pc, m_ipc, m_instr, m_v, m_sc, m_fc);
            @(negedge clk_i);
            rst_i = 1'b1;
         end
         s  = ($urandom_range(0, 9) != 0);
         st = ($urandom_range(0, 3) == 0);
         f  = ($urandom_range(0, 5) == 0);
         b  = ($urandom_range(0, 5) == 0);
         t  = $urandom;
         if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFFC | {30'h0, t[1:0]};
         start_i = s; stall_i = st; flush_i = f; branch_i = b; branch_target_i = t;
         model_step(s, st, f, b, t);
         @(posedge clk_i);
         #1;
         check_all($sformatf("rnd%0d", n), m_pc, m_ipc, m_instr, m_v, m_sc, m_fc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
